// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the loadable countdown timer.
package countdown_timer_pkg;

    // Default bit width of the count and the load value.
    localparam int unsigned DEFAULT_SIZE = 5;

    // Largest loadable value at the default width (all ones).
    localparam logic [DEFAULT_SIZE-1:0] MAX_COUNT = '1;

    // Controller state: IDLE waits for a load, RUN counts down.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/down_count_core.sv
// Count register with clear, load and decrement, plus a next-value-is-zero flag.
// Priority: clear over load over decrement. Decrement saturates at zero.
module down_count_core
    import countdown_timer_pkg::*;
#(
    parameter int unsigned Size = DEFAULT_SIZE
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            load_i,
    input  logic [Size-1:0] load_val_i,
    input  logic            dec_i,
    output logic [Size-1:0] count_o,
    output logic            zero_next_o
);

    localparam logic [Size-1:0] ONE = {{(Size-1){1'b0}}, 1'b1};

    logic [Size-1:0] count_q;
    logic [Size-1:0] count_d;

    // Select the next count value; never decrements below zero.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    // A decrement this cycle lands on zero exactly when the current value is one.
    assign zero_next_o = ((count_q - ONE) == '0);

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with valid/ready load, one-shot or periodic mode,
// pause via enable, synchronous abort and a registered one-cycle done pulse.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned Size = DEFAULT_SIZE
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load_valid,
    input  logic [Size-1:0] load_value,
    output logic            load_ready,
    input  logic            auto_reload,
    input  logic            enable,
    input  logic            abort,
    output logic [Size-1:0] count,
    output logic            running,
    output logic            done
);

    state_e          state_q, state_d;
    logic [Size-1:0] period_q, period_d;
    logic            reload_q, reload_d;
    logic            done_q, done_d;
    logic            running_q;

    logic            accept;
    logic            load_zero;
    logic            step;
    logic            zero_next;
    logic            expire;
    logic            core_load;
    logic [Size-1:0] core_load_val;

    // Abort blocks a simultaneous load so it is never treated as accepted.
    assign accept    = load_valid && load_ready && !abort;
    assign load_zero = (load_value == '0);
    assign step      = (state_q == RUN) && enable;
    assign expire    = step && zero_next;

    // A periodic expiry reloads the count from the period register;
    // a new load always takes precedence over that reload.
    assign core_load     = accept || (expire && reload_q);
    assign core_load_val = accept ? load_value : period_q;

    down_count_core #(
        .Size (Size)
    ) u_core (
        .clk_i       (clock),
        .rst_ni      (reset),
        .clr_i       (abort),
        .load_i      (core_load),
        .load_val_i  (core_load_val),
        .dec_i       (step),
        .count_o     (count),
        .zero_next_o (zero_next)
    );

    // State, period, reload flag and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            period_q  <= '0;
            reload_q  <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            reload_q  <= reload_d;
            done_q    <= done_d;
            running_q <= (state_d == RUN);
        end
    end

    // Next state: abort, then load, then expiry. A zero load never enters RUN
    // and never arms periodic mode, which would otherwise expire forever.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (abort) begin
            state_d  = IDLE;
            reload_d = 1'b0;
        end else if (accept) begin
            period_d = load_value;
            reload_d = auto_reload && !load_zero;
            state_d  = load_zero ? IDLE : RUN;
            done_d   = load_zero || expire;
        end else if (expire) begin
            done_d = 1'b1;
            if (!reload_q) begin
                state_d = IDLE;
            end
        end
    end

    // Outputs: load_ready depends only on registered state and reload flag.
    always_comb begin
        load_ready = (state_q == IDLE) || !reload_q;
        running    = running_q;
        done       = done_q;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus a
// randomized run against a behavioural model of the timer's rules.
module tb_countdown_timer;

    localparam int W = 5;

    logic         clock = 1'b0;
    logic         reset;
    logic         load_valid;
    logic [W-1:0] load_value;
    logic         load_ready;
    logic         auto_reload;
    logic         enable;
    logic         abort;
    logic [W-1:0] count;
    logic         running;
    logic         done;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [W-1:0] m_count;
    logic [W-1:0] m_period;
    bit           m_run;
    bit           m_reload;
    bit           m_done;

    countdown_timer #(.Size(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_value  (load_value),
        .load_ready  (load_ready),
        .auto_reload (auto_reload),
        .enable      (enable),
        .abort       (abort),
        .count       (count),
        .running     (running),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic model_clear();
        m_count  = '0;
        m_period = '0;
        m_run    = 0;
        m_reload = 0;
        m_done   = 0;
    endtask

    // Applies one rising edge worth of the timer's rules to the model.
    task automatic model_step();
        bit rdy;
        bit expire;
        if (!reset) begin
            model_clear();
            return;
        end
        rdy    = !m_run || !m_reload;
        expire = m_run && enable && (m_count == 1);
        m_done = 0;
        if (abort) begin
            m_run    = 0;
            m_count  = '0;
            m_reload = 0;
        end else if (load_valid && rdy) begin
            m_done   = expire || (load_value == 0);
            m_count  = load_value;
            m_period = load_value;
            m_reload = auto_reload && (load_value != 0);
            m_run    = (load_value != 0);
        end else if (expire) begin
            m_done = 1;
            if (m_reload) m_count = m_period;
            else begin
                m_count = '0;
                m_run   = 0;
            end
        end else if (m_run && enable) begin
            m_count = m_count - 1'b1;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        load_valid  = 0;
        load_value  = '0;
        auto_reload = 0;
        enable      = 0;
        abort       = 0;
    endtask

    task automatic test_reset();
        quiet();
        reset = 0;
        model_clear();
        #12;
        n_cmp++;
        if ({count, running, done, load_ready} !== {5'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_init got cnt=%0d run=%b done=%b rdy=%b want 0 0 0 1", count, running, done, load_ready);
        end
        @(negedge clock);
        reset = 1;
        load_valid = 1; load_value = 5'd10; enable = 1;
        cycle();
        load_valid = 0;
        repeat (3) cycle();
        n_cmp++;
        if ({count, running} !== {5'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_pre got cnt=%0d run=%b want 7 1", count, running);
        end
        #2 reset = 0;
        #1;
        model_clear();
        n_cmp++;
        if ({count, running, done, load_ready} !== {5'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_async got cnt=%0d run=%b done=%b rdy=%b want 0 0 0 1", count, running, done, load_ready);
        end
        #3 reset = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if ({count, running, done} !== {5'd0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_idle[%0d] got cnt=%0d run=%b done=%b want 0 0 0", i, count, running, done);
            end
        end
    endtask

    task automatic test_one_shot();
        quiet();
        load_valid = 1; load_value = 5'd5; enable = 1;
        cycle();
        load_valid = 0;
        n_cmp++;
        if ({count, running, done} !== {5'd5, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL oneshot_load got cnt=%0d run=%b done=%b want 5 1 0", count, running, done);
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_cmp++;
            if ({count, done} !== {5'(4 - i), (i == 4)}) begin
                n_fail++;
                $display("FAIL oneshot_seq[%0d] got cnt=%0d done=%b want %0d %b", i, count, done, 4 - i, (i == 4));
            end
        end
        cycle();
        n_cmp++;
        if ({count, running, done, load_ready} !== {5'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL oneshot_idle got cnt=%0d run=%b done=%b rdy=%b want 0 0 0 1", count, running, done, load_ready);
        end
    endtask

    task automatic test_periodic();
        int pulses = 0;
        quiet();
        load_valid = 1; load_value = 5'd3; auto_reload = 1; enable = 1;
        cycle();
        n_cmp++;
        if ({count, running, load_ready} !== {5'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL periodic_load got cnt=%0d run=%b rdy=%b want 3 1 0", count, running, load_ready);
        end
        for (int k = 1; k <= 12; k++) begin
            // Loads offered while periodic must be refused.
            load_valid = 1; load_value = 5'($urandom_range(1, 31)); auto_reload = 0;
            cycle();
            if (done) pulses++;
            n_cmp++;
            if ({count, done, load_ready, running} !== {((k % 3 == 0) ? 5'd3 : 5'(3 - k % 3)), (k % 3 == 0), 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL periodic_seq[%0d] got cnt=%0d done=%b rdy=%b run=%b", k, count, done, load_ready, running);
            end
        end
        n_cmp++;
        if (pulses !== 4) begin
            n_fail++;
            $display("FAIL periodic_pulses got %0d want 4", pulses);
        end
        load_valid = 0; abort = 1;
        cycle();
        abort = 0;
        n_cmp++;
        if ({count, running, done, load_ready} !== {5'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL periodic_abort got cnt=%0d run=%b done=%b rdy=%b want 0 0 0 1", count, running, done, load_ready);
        end
    endtask

    task automatic test_pause();
        bit       en_pat [6] = '{1, 0, 0, 1, 1, 1};
        logic [W-1:0] exp_c [6] = '{5'd3, 5'd3, 5'd3, 5'd2, 5'd1, 5'd0};
        quiet();
        load_valid = 1; load_value = 5'd4; enable = 1;
        cycle();
        load_valid = 0;
        for (int i = 0; i < 6; i++) begin
            enable = en_pat[i];
            cycle();
            n_cmp++;
            if ({count, done} !== {exp_c[i], (i == 5)}) begin
                n_fail++;
                $display("FAIL pause[%0d] got cnt=%0d done=%b want %0d %b", i, count, done, exp_c[i], (i == 5));
            end
        end
        enable = 0;
        cycle();
    endtask

    task automatic test_edges();
        int n = 0;
        bit seen = 0;
        quiet();
        load_valid = 1; load_value = 5'd0; auto_reload = 1; enable = 1;
        cycle();
        load_valid = 0;
        n_cmp++;
        if ({count, running, done, load_ready} !== {5'd0, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_load got cnt=%0d run=%b done=%b rdy=%b want 0 0 1 1", count, running, done, load_ready);
        end
        cycle();
        n_cmp++;
        if ({running, done} !== {1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_after got run=%b done=%b want 0 0", running, done);
        end
        load_valid = 1; load_value = 5'd31; auto_reload = 0;
        cycle();
        load_valid = 0;
        while (!seen && n < 40) begin
            cycle();
            n++;
            if (done) seen = 1;
            if (!seen && count !== 5'(31 - n)) begin
                n_cmp++;
                n_fail++;
                $display("FAIL max_seq[%0d] got cnt=%0d want %0d", n, count, 31 - n);
            end
        end
        n_cmp++;
        if (!seen || n !== 31 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL max_load got cycles=%0d seen=%b cnt=%0d want 31 1 0", n, seen, count);
        end
        enable = 0;
        cycle();
    endtask

    task automatic test_collisions();
        quiet();
        load_valid = 1; load_value = 5'd2; enable = 1;
        cycle();
        load_valid = 0;
        cycle();
        load_valid = 1; load_value = 5'd6;
        cycle();
        load_valid = 0;
        n_cmp++;
        if ({count, running, done} !== {5'd6, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL restart_expiry got cnt=%0d run=%b done=%b want 6 1 1", count, running, done);
        end
        cycle();
        n_cmp++;
        if ({count, running, done} !== {5'd5, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL restart_next got cnt=%0d run=%b done=%b want 5 1 0", count, running, done);
        end
        abort = 1; load_valid = 1; load_value = 5'd9;
        cycle();
        abort = 0; load_valid = 0;
        n_cmp++;
        if ({count, running, done} !== {5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_load got cnt=%0d run=%b done=%b want 0 0 0", count, running, done);
        end
        cycle();
        n_cmp++;
        if ({count, running} !== {5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_idle got cnt=%0d run=%b want 0 0", count, running);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            load_valid  = ($urandom_range(0, 7) == 0);
            load_value  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            auto_reload = $urandom_range(0, 1);
            enable      = ($urandom_range(0, 3) != 0);
            abort       = ($urandom_range(0, 47) == 0);
            cycle();
            n_cmp++;
            if ({count, running, done, load_ready} !== {m_count, m_run, m_done, (!m_run || !m_reload)}) begin
                n_fail++;
                $display("FAIL random[%0d] got cnt=%0d run=%b done=%b rdy=%b want %0d %b %b %b", i,
                         count, running, done, load_ready, m_count, m_run, m_done, (!m_run || !m_reload));
            end
        end
        quiet();
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_pause();
        test_edges();
        test_collisions();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
